ram_port_arbiter: RTL and testbench

- Shares the single BlockRam port between two requesters:
  - the CPU (fetch and load/store path);
  - the I/O requester (puzzle-module peripheral DMA engine that moves panel/LED/switch state in and out of RAM).
- Registered req/gnt handshake, round-robin fairness and a burst limit, so neither side starves.
- Sits between both requesters and BlockRam; drives BlockRam data, read/write address, we and re.

---
 rtl/ram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbiter sharing one BlockRam port between the CPU and the I/O DMA requester.
// Round-robin on ties, a burst cap under contention, and per-side read-valid return.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  input  logic                  io_req,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_gnt,
  output logic                  io_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_IO  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_io_q, last_io_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             io_rvalid_q, io_rvalid_d;

  logic             own_cpu_s, own_io_s;
  logic             cpu_acc_s, io_acc_s;
  logic [CNT_W-1:0] burst_inc_s;
  logic             burst_hit_s;

  assign own_cpu_s   = (state_q == ST_OWN_CPU);
  assign own_io_s    = (state_q == ST_OWN_IO);
  // An access in flight while reset is asserted is dropped at the RAM as well.
  assign cpu_acc_s   = own_cpu_s & cpu_req & reset;
  assign io_acc_s    = own_io_s & io_req & reset;
  assign burst_inc_s = (burst_q == BURST_MAX) ? burst_q : (burst_q + CNT_ONE);
  assign burst_hit_s = (burst_inc_s == BURST_MAX);

  always_comb begin
    state_d      = state_q;
    last_io_d    = last_io_q;
    burst_d      = burst_q;
    cpu_rvalid_d = cpu_acc_s & ~cpu_we;
    io_rvalid_d  = io_acc_s & ~io_we;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (cpu_req && (!io_req || last_io_q)) begin
          state_d = ST_OWN_CPU;
        end else if (io_req) begin
          state_d = ST_OWN_IO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_CPU: begin
        if (!cpu_req) begin
          last_io_d = 1'b0;
          burst_d   = '0;
          state_d   = io_req ? ST_OWN_IO : ST_IDLE;
        end else if (burst_hit_s && io_req) begin
          last_io_d = 1'b0;
          burst_d   = '0;
          state_d   = ST_OWN_IO;
        end else begin
          burst_d = burst_inc_s;
        end
      end
      ST_OWN_IO: begin
        if (!io_req) begin
          last_io_d = 1'b1;
          burst_d   = '0;
          state_d   = cpu_req ? ST_OWN_CPU : ST_IDLE;
        end else if (burst_hit_s && cpu_req) begin
          last_io_d = 1'b1;
          burst_d   = '0;
          state_d   = ST_OWN_CPU;
        end else begin
          burst_d = burst_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_io_q    <= 1'b1;
      burst_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      io_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_io_q    <= last_io_d;
      burst_q      <= burst_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      io_rvalid_q  <= io_rvalid_d;
    end
  end

  // Idle port presents the CPU's address/data with both strobes low.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_acc_s) begin
      mem_we = cpu_we;
      mem_re = ~cpu_we;
    end else if (io_acc_s) begin
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
      mem_we    = io_we;
      mem_re    = ~io_we;
    end else begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  assign cpu_gnt    = own_cpu_s;
  assign io_gnt     = own_io_s;
  assign busy       = own_cpu_s | own_io_s;
  assign cpu_rvalid = cpu_rvalid_q;
  assign io_rvalid  = io_rvalid_q;
  assign rdata      = mem_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: cycle table plus burst/preempt/reset sequences
// against a 1-cycle-latency BlockRam model.
module tb_ram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_q;
  logic        mem_we, mem_re, busy;

  logic [15:0] mem [0:65535];

  int tests = 0;
  int fails = 0;
  int step  = 0;

  typedef struct packed {
    logic        rst;
    logic        cr, cw;
    logic [15:0] ca, cd;
    logic        ir, iw;
    logic [15:0] ia, id;
    logic        cg, ig, crv, irv, we, re;
    logic [15:0] ma, mwd;
    logic        chk_mem;
    logic        chk_rd;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs [10];
  vec_t v;

  ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_BURST(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_q(mem_q), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_q <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (step %0d): got 0x%h, expected 0x%h", nm, step, act, exp);
    end
  endtask

  function automatic vec_t iv(input logic cr, input logic cw, input logic [15:0] ca,
                              input logic [15:0] cd, input logic ir, input logic iw,
                              input logic [15:0] ia, input logic [15:0] id);
    vec_t r;
    r = '0;
    r.rst = 1'b1;
    r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.ir = ir; r.iw = iw; r.ia = ia; r.id = id;
    r.ma = ca; r.mwd = cd;
    r.chk_mem = 1'b1;
    return r;
  endfunction

  task automatic apply(input vec_t x);
    @(negedge clock);
    reset = x.rst;
    cpu_req = x.cr; cpu_we = x.cw; cpu_addr = x.ca; cpu_wdata = x.cd;
    io_req = x.ir; io_we = x.iw; io_addr = x.ia; io_wdata = x.id;
    #2;
    chk("cpu_gnt", 16'(cpu_gnt), 16'(x.cg));
    chk("io_gnt", 16'(io_gnt), 16'(x.ig));
    chk("busy", 16'(busy), 16'(x.cg | x.ig));
    chk("cpu_rvalid", 16'(cpu_rvalid), 16'(x.crv));
    chk("io_rvalid", 16'(io_rvalid), 16'(x.irv));
    if (x.chk_mem) begin
      chk("mem_we", 16'(mem_we), 16'(x.we));
      chk("mem_re", 16'(mem_re), 16'(x.re));
      chk("mem_addr", mem_addr, x.ma);
      chk("mem_wdata", mem_wdata, x.mwd);
    end
    if (x.chk_rd) chk("rdata", rdata, x.rd);
    step++;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    io_req = 1'b0; io_we = 1'b0; io_addr = 16'h0000; io_wdata = 16'h0000;
    mem_q = 16'h0000;
    mem[16'h0010] = 16'hBEEF;

    // Reset with both requesting, CPU wins the first tie, single read, write, handover
    vecs[0] = iv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
    vecs[0].rst = 1'b0;
    vecs[1] = vecs[0];
    vecs[2] = iv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
    vecs[3] = iv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0020, 16'h0000);
    vecs[3].cg = 1'b1; vecs[3].re = 1'b1;
    vecs[4] = iv(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0020, 16'h0000);
    vecs[4].cg = 1'b1; vecs[4].crv = 1'b1; vecs[4].chk_rd = 1'b1; vecs[4].rd = 16'hBEEF;
    vecs[5] = iv(1'b1, 1'b1, 16'h0030, 16'h1234, 1'b0, 1'b0, 16'h0020, 16'h0000);
    vecs[6] = iv(1'b1, 1'b1, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'h0000);
    vecs[6].cg = 1'b1; vecs[6].we = 1'b1;
    vecs[7] = iv(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'h0000);
    vecs[7].cg = 1'b1;
    vecs[8] = iv(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h0030, 16'h0000);
    vecs[8].ig = 1'b1; vecs[8].re = 1'b1; vecs[8].ma = 16'h0030; vecs[8].mwd = 16'h0000;
    vecs[9] = iv(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b0, 1'b0, 16'h0030, 16'h0000);
    vecs[9].ig = 1'b1; vecs[9].irv = 1'b1; vecs[9].chk_rd = 1'b1; vecs[9].rd = 16'h1234;

    @(posedge clock);
    for (int i = 0; i < 10; i++) apply(vecs[i]);

    // I/O takes the idle port, then 8 writes under CPU contention before losing it
    v = iv(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'hA000);
    apply(v);
    for (int k = 0; k < 8; k++) begin
      v = iv(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b1, 16'h0100 + 16'(k), 16'hA000 + 16'(k));
      v.ig = 1'b1; v.we = 1'b1; v.ma = 16'h0100 + 16'(k); v.mwd = 16'hA000 + 16'(k);
      apply(v);
    end
    // CPU reads the burst back; I/O keeps requesting
    for (int j = 0; j < 8; j++) begin
      v = iv(1'b1, 1'b0, 16'h0100 + 16'(j), 16'h0000, 1'b1, 1'b1, 16'h0108, 16'hA008);
      v.cg = 1'b1; v.re = 1'b1;
      if (j > 0) begin
        v.crv = 1'b1; v.chk_rd = 1'b1; v.rd = 16'hA000 + 16'(j - 1);
      end
      apply(v);
    end
    // I/O regains the port at 0x0108; its final access reads 0x0107
    for (int k = 0; k < 8; k++) begin
      v = iv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, (k < 7),
             (k < 7) ? 16'h0108 + 16'(k) : 16'h0107, 16'hB000 + 16'(k));
      v.ig = 1'b1; v.we = (k < 7); v.re = (k == 7);
      v.ma = v.ia; v.mwd = v.id;
      if (k == 0) begin
        v.crv = 1'b1; v.chk_rd = 1'b1; v.rd = 16'hA007;
      end
      apply(v);
    end
    // Preempted read returns to I/O while the CPU already holds the port
    v = iv(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'hB008);
    v.cg = 1'b1; v.re = 1'b1; v.irv = 1'b1; v.chk_rd = 1'b1; v.rd = 16'hA007;
    apply(v);
    v = iv(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'hB008);
    v.cg = 1'b1; v.crv = 1'b1; v.chk_rd = 1'b1; v.rd = 16'hBEEF;
    apply(v);
    // Reset during an I/O read: no rvalid afterwards, then regrant to I/O
    v = iv(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
    v.rst = 1'b0; v.ig = 1'b1; v.chk_mem = 1'b0;
    apply(v);
    v = iv(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
    apply(v);
    v.ig = 1'b1; v.re = 1'b1;
    apply(v);
    v = iv(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000);
    v.ig = 1'b1; v.irv = 1'b1; v.chk_rd = 1'b1; v.rd = 16'hBEEF;
    apply(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
